// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand fetch stage.
//   state_t     : fetch FSM states (IDLE, READ_A, READ_B, HOLD)
//   SH_*        : shift codes carried alongside the operands
//   REG_IDX_W   : register index width (8 registers)
package operand_fetch_stage_pkg;

  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned NUM_REGS  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    READ_A = 2'b01,
    READ_B = 2'b10,
    HOLD   = 2'b11
  } state_t;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/operand_fetch_stage_regfile.sv
// 8 x k register file.
//   clk, rst_n          : clock, async active-low clear of all entries
//   wr_en/wr_num/wr_data: synchronous write port
//   rd_num/rd_data      : combinational read port; a same-cycle write to the
//                         same index is forwarded (write-first)
module regfile_8xk
  import operand_fetch_stage_pkg::*;
#(
  parameter int unsigned k = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_num,
  input  logic [k-1:0]         wr_data,
  input  logic [REG_IDX_W-1:0] rd_num,
  output logic [k-1:0]         rd_data
);

  logic [k-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_num] <= wr_data;
    end
  end

  always_comb begin
    rd_data = mem[rd_num];
    if (wr_en && (wr_num == rd_num)) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads Rn into A and Rm into B on consecutive cycles
// after each accepted request, then holds {A, B, shift code} for the
// shifter/ALU stage until op_ready.
//   clk, rst_n                 : clock, async active-low reset
//   wr_en, wr_num, wr_data     : writeback port, independent of the read sequence
//   req_valid, req_ready       : request handshake (ready only in IDLE)
//   rn, rm, shift_in           : request fields, latched on accept
//   op_valid, op_ready         : operand handshake (valid only in HOLD)
//   a_out, b_out, shift_out    : operand snapshots and latched shift code
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int unsigned k = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_num,
  input  logic [k-1:0]         wr_data,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [REG_IDX_W-1:0] rn,
  input  logic [REG_IDX_W-1:0] rm,
  input  logic [1:0]           shift_in,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [k-1:0]         a_out,
  output logic [k-1:0]         b_out,
  output logic [1:0]           shift_out
);

  state_t               state;
  logic [REG_IDX_W-1:0] rn_q;
  logic [REG_IDX_W-1:0] rm_q;
  logic [REG_IDX_W-1:0] rd_num;
  logic [k-1:0]         rd_data;

  // One read port suffices: A and B are fetched in different cycles.
  assign rd_num    = (state == READ_A) ? rn_q : rm_q;
  assign req_ready = (state == IDLE);

  regfile_8xk #(.k(k)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_num  (wr_num),
    .wr_data (wr_data),
    .rd_num  (rd_num),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rn_q      <= '0;
      rm_q      <= '0;
      shift_out <= SH_NONE;
      a_out     <= '0;
      b_out     <= '0;
      op_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rn_q      <= rn;
            rm_q      <= rm;
            shift_out <= shift_in;
            state     <= READ_A;
          end
        end
        READ_A: begin
          a_out <= rd_data;
          state <= READ_B;
        end
        READ_B: begin
          b_out    <= rd_data;
          op_valid <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

  localparam int unsigned K = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [2:0]   wr_num;
  logic [K-1:0] wr_data;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   rn;
  logic [2:0]   rm;
  logic [1:0]   shift_in;
  logic         op_valid;
  logic         op_ready;
  logic [K-1:0] a_out;
  logic [K-1:0] b_out;
  logic [1:0]   shift_out;

  operand_fetch_stage #(.k(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_num    (wr_num),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rn        (rn),
    .rm        (rm),
    .shift_in  (shift_in),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .shift_out (shift_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   rn;
    logic [2:0]   rm;
    logic [1:0]   sh;
    logic [K-1:0] ea;
    logic [K-1:0] eb;
  } vec_t;

  vec_t vecs [5];

  // Back-to-back monitor: counts accepts and handshakes, checks operands.
  logic bb_mode = 1'b0;
  int   acc = 0;
  int   hs  = 0;
  always @(posedge clk) begin
    if (bb_mode) begin
      if (req_valid && req_ready) acc++;
      if (op_valid && op_ready) begin
        hs++;
        chk("bb_a", 32'(a_out), 32'h0005);
        chk("bb_b", 32'(b_out), 32'h0005);
      end
    end
  end

  task automatic wr(input logic [2:0] idx, input logic [K-1:0] d);
    wr_en = 1'b1; wr_num = idx; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Accept a request and wait (bounded) for op_valid; checks 2-edge latency.
  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh);
    int cyc;
    chk("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; rn = a; rm = b; shift_in = sh;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!op_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd2);
  endtask

  task automatic handshake();
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    chk("op_valid_after_hs", 32'(op_valid), 32'd0);
    chk("req_ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int vcnt;
    rst_n = 1'b0; wr_en = 1'b0; wr_num = '0; wr_data = '0;
    req_valid = 1'b0; rn = '0; rm = '0; shift_in = '0; op_ready = 1'b0;

    vecs[0] = '{rn: 3'd3, rm: 3'd5, sh: 2'b11, ea: 16'h00F0, eb: 16'h8001};
    vecs[1] = '{rn: 3'd0, rm: 3'd7, sh: 2'b00, ea: 16'h0000, eb: 16'h7777};
    vecs[2] = '{rn: 3'd1, rm: 3'd2, sh: 2'b01, ea: 16'h1111, eb: 16'h2222};
    vecs[3] = '{rn: 3'd6, rm: 3'd6, sh: 2'b10, ea: 16'h6666, eb: 16'h6666};
    vecs[4] = '{rn: 3'd7, rm: 3'd0, sh: 2'b11, ea: 16'h7777, eb: 16'h0000};

    repeat (2) @(negedge clk);
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_a", 32'(a_out), 32'd0);
    chk("rst_b", 32'(b_out), 32'd0);
    chk("rst_shift", 32'(shift_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    // Preload registers
    wr(3'd1, 16'h1111); wr(3'd2, 16'h2222); wr(3'd3, 16'h00F0);
    wr(3'd4, 16'h4444); wr(3'd5, 16'h8001); wr(3'd6, 16'h6666);
    wr(3'd7, 16'h7777);

    // Table-driven requests
    foreach (vecs[i]) begin
      issue(vecs[i].rn, vecs[i].rm, vecs[i].sh);
      chk($sformatf("vec%0d_a", i), 32'(a_out), 32'(vecs[i].ea));
      chk($sformatf("vec%0d_b", i), 32'(b_out), 32'(vecs[i].eb));
      chk($sformatf("vec%0d_sh", i), 32'(shift_out), 32'(vecs[i].sh));
      handshake();
    end

    // Backpressure with a write to Rn while holding
    issue(3'd3, 3'd5, 2'b11);
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        wr_en = 1'b1; wr_num = 3'd3; wr_data = 16'hFFFF;
      end
      @(negedge clk);
      wr_en = 1'b0;
      chk("bp_a_stable", 32'(a_out), 32'h00F0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_op_valid", 32'(op_valid), 32'd1);
    end
    handshake();
    issue(3'd3, 3'd3, 2'b00);
    chk("r3_written_a", 32'(a_out), 32'hFFFF);
    chk("r3_written_b", 32'(b_out), 32'hFFFF);
    handshake();

    // Write-first bypass in READ_A and READ_B cycles
    req_valid = 1'b1; rn = 3'd3; rm = 3'd5; shift_in = 2'b01;
    @(negedge clk);
    req_valid = 1'b0;
    wr_en = 1'b1; wr_num = 3'd3; wr_data = 16'h1234;
    @(negedge clk);
    wr_en = 1'b1; wr_num = 3'd5; wr_data = 16'hABCD;
    @(negedge clk);
    wr_en = 1'b0;
    chk("byp_op_valid", 32'(op_valid), 32'd1);
    chk("byp_a", 32'(a_out), 32'h1234);
    chk("byp_b", 32'(b_out), 32'hABCD);
    handshake();

    // rn == rm, back-to-back requests
    wr(3'd7, 16'h0005);
    bb_mode = 1'b1;
    req_valid = 1'b1; rn = 3'd7; rm = 3'd7; shift_in = 2'b10; op_ready = 1'b1;
    repeat (20) @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    op_ready = 1'b0;
    bb_mode = 1'b0;
    chk("bb_accepts", 32'(acc), 32'd5);
    chk("bb_handshakes", 32'(hs), 32'd5);

    // req_valid pulses outside IDLE are ignored
    req_valid = 1'b1; rn = 3'd1; rm = 3'd2; shift_in = 2'b01;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; rn = 3'd6; rm = 3'd6; shift_in = 2'b00;
    chk("ign_req_ready_readb", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ign_op_valid", 32'(op_valid), 32'd1);
    chk("ign_req_ready_hold", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ign_a", 32'(a_out), 32'h1111);
    chk("ign_b", 32'(b_out), 32'h2222);
    chk("ign_sh", 32'(shift_out), 32'b01);
    handshake();
    vcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (op_valid || !req_ready) vcnt++;
    end
    chk("ign_no_extra_op", 32'(vcnt), 32'd0);

    // Reset in the middle of HOLD
    issue(3'd1, 3'd2, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_op_valid", 32'(op_valid), 32'd0);
    chk("midrst_a", 32'(a_out), 32'd0);
    chk("midrst_b", 32'(b_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_no_op", 32'(op_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 3'(i), 2'b00);
      chk($sformatf("clr_r%0d_a", i), 32'(a_out), 32'd0);
      chk($sformatf("clr_r%0d_b", i), 32'(b_out), 32'd0);
      handshake();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
